// File: rtl/audio_pkg.sv
// ============================================================================
// Module      : audio_pkg
// Description : Shared types, constants and helpers for the audio mix path.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package audio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACC   = 3'd1,
        ST_SCALE = 3'd2,
        ST_SAT   = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    function automatic int gain_unity(input int gain_bits);
        return 1 << (gain_bits - 1);
    endfunction

    localparam int          c_GAIN_UNITY = gain_unity(8);
    localparam logic [15:0] c_LFSR_SEED  = 16'hACE1;
    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1
    localparam logic [15:0] c_LFSR_TAPS  = 16'h002D;

    function automatic logic signed [63:0] sat_signed(
        input logic signed [63:0] v,
        input int                 bits
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (bits - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/audio_mix_out_tick.sv
// ============================================================================
// Module      : sample_tick_gen
// Description : Free-running prescaler producing a one-cycle sample tick.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sample_tick_gen #(
    parameter int F_CLK    = 50_000_000,
    parameter int F_SAMPLE = 48_000
) (
    input  logic clk,
    input  logic reset,
    output logic o_tick
);

    localparam int c_DIV = F_CLK / F_SAMPLE;
    localparam int c_CW  = (c_DIV > 1) ? $clog2(c_DIV) : 1;

    logic [c_CW-1:0] r_count;
    logic            w_last;

    assign w_last = (r_count == c_CW'(c_DIV - 1));
    assign o_tick = w_last;

    always_ff @(posedge clk) begin
        if (reset)
            r_count <= '0;
        else if (w_last)
            r_count <= '0;
        else
            r_count <= r_count + 1'b1;
    end

endmodule

`default_nettype wire

// File: rtl/audio_mix_out.sv
// ============================================================================
// Module      : audio_mix_out
// Description : N-channel gain/mix/saturate path to an offset-binary DAC
//               sample with valid/ready output. AUDIO_MIX_DITHER_EN adds
//               LFSR rectangular dither ahead of the final truncation.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module audio_mix_out
    import audio_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int SIG_BITS  = 16,
    parameter int GAIN_BITS = 8,
    parameter int OUT_BITS  = 16,
    parameter int F_CLK     = 50_000_000,
    parameter int F_SAMPLE  = 48_000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_CH*SIG_BITS-1:0]  ch_in,
    input  logic [N_CH*GAIN_BITS-1:0] ch_gain,
    input  logic [GAIN_BITS-1:0]      master_gain,
    output logic [OUT_BITS-1:0]       out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [15:0]               overrun_cnt
);

    localparam int c_SHIFT = $clog2(gain_unity(GAIN_BITS));
    localparam int c_IDXW  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int c_ACCW  = SIG_BITS + GAIN_BITS + $clog2(N_CH) + 1;
    localparam int c_PW    = c_ACCW + GAIN_BITS + 1;

    state_t                      r_state;
    logic [N_CH*SIG_BITS-1:0]    r_snap_ch;
    logic [N_CH*GAIN_BITS-1:0]   r_snap_gain;
    logic [GAIN_BITS-1:0]        r_snap_master;
    logic [c_IDXW-1:0]           r_idx;
    logic signed [c_ACCW-1:0]    r_acc;
    logic signed [c_PW-1:0]      r_p;
    logic [OUT_BITS-1:0]         r_out_data;
    logic                        r_out_valid;
    logic [15:0]                 r_overrun;

    logic                        w_tick;
    logic                        w_accept;
    logic signed [SIG_BITS-1:0]  w_ch;
    logic [GAIN_BITS-1:0]        w_gain;
    logic signed [c_ACCW-1:0]    w_prod;
    logic signed [c_ACCW-1:0]    w_acc_shr;
    logic signed [c_PW-1:0]      w_scaled;
    logic [c_SHIFT-1:0]          w_dith;
    logic signed [c_PW-1:0]      w_p_dith;
    logic signed [c_PW-1:0]      w_s;
    logic signed [63:0]          w_s_ext;
    logic [OUT_BITS-1:0]         w_sat;

    sample_tick_gen #(
        .F_CLK    (F_CLK),
        .F_SAMPLE (F_SAMPLE)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .o_tick (w_tick)
    );

    // A tick lands on a free pipeline or on the very cycle the held sample is taken
    assign w_accept = w_tick && ((r_state == ST_IDLE) || (r_state == ST_OUT && out_ready));

    assign w_ch      = $signed(r_snap_ch[r_idx*SIG_BITS +: SIG_BITS]);
    assign w_gain    = r_snap_gain[r_idx*GAIN_BITS +: GAIN_BITS];
    assign w_prod    = w_ch * $signed({1'b0, w_gain});
    assign w_acc_shr = r_acc >>> c_SHIFT;
    assign w_scaled  = w_acc_shr * $signed({1'b0, r_snap_master});
    assign w_p_dith  = r_p + $signed({{(c_PW - c_SHIFT){1'b0}}, w_dith});
    assign w_s       = w_p_dith >>> c_SHIFT;
    assign w_s_ext   = {{(64 - c_PW){w_s[c_PW-1]}}, w_s};
    assign w_sat     = OUT_BITS'(sat_signed(w_s_ext, OUT_BITS));

`ifdef AUDIO_MIX_DITHER_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (reset)
            r_lfsr <= c_LFSR_SEED;
        else if (w_accept)
            r_lfsr <= {^(r_lfsr & c_LFSR_TAPS), r_lfsr[15:1]};
    end

    assign w_dith = r_lfsr[c_SHIFT-1:0];
`else
    assign w_dith = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_snap_ch     <= '0;
            r_snap_gain   <= '0;
            r_snap_master <= '0;
            r_idx         <= '0;
            r_acc         <= '0;
            r_p           <= '0;
            r_out_data    <= {1'b1, {(OUT_BITS-1){1'b0}}};
            r_out_valid   <= 1'b0;
            r_overrun     <= '0;
        end else begin
            if (w_tick && !w_accept && r_overrun != 16'hFFFF)
                r_overrun <= r_overrun + 1'b1;

            if (w_accept) begin
                r_snap_ch     <= ch_in;
                r_snap_gain   <= ch_gain;
                r_snap_master <= master_gain;
                r_idx         <= '0;
                r_acc         <= '0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept)
                        r_state <= ST_ACC;
                end
                ST_ACC: begin
                    r_acc <= r_acc + w_prod;
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == c_IDXW'(N_CH - 1))
                        r_state <= ST_SCALE;
                end
                ST_SCALE: begin
                    r_p     <= w_scaled;
                    r_state <= ST_SAT;
                end
                ST_SAT: begin
                    r_out_data  <= {~w_sat[OUT_BITS-1], w_sat[OUT_BITS-2:0]};
                    r_out_valid <= 1'b1;
                    r_state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= w_accept ? ST_ACC : ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign overrun_cnt = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_audio_mix_out.sv
// ============================================================================
// Module      : tb_audio_mix_out
// Description : Scoreboard bench for audio_mix_out at default parameters.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_audio_mix_out;
    import audio_pkg::*;

    localparam int N_CH = 4;
    localparam int DIV  = 50_000_000 / 48_000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] ch_in = '0;
    logic [31:0] ch_gain = '0;
    logic [7:0]  master_gain = '0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] overrun_cnt;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_tick_cyc = 0;
    logic [15:0] exp_q[$];
    logic [15:0] m_lfsr = c_LFSR_SEED;

    audio_mix_out dut (
        .clk         (clk),
        .reset       (reset),
        .ch_in       (ch_in),
        .ch_gain     (ch_gain),
        .master_gain (master_gain),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun_cnt (overrun_cnt)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (dut.u_tick.o_tick) last_tick_cyc <= cyc;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    function automatic logic [15:0] model(input logic [63:0] chs, input logic [31:0] gains,
                                          input logic [7:0] mg, input logic [15:0] lfsr);
        longint acc, p, s;
        logic [15:0] r;
        acc = 0;
        for (int k = 0; k < N_CH; k++)
            acc += longint'($signed(chs[k*16 +: 16])) * longint'(gains[k*8 +: 8]);
        p = (acc >>> 7) * longint'(mg);
`ifdef AUDIO_MIX_DITHER_EN
        p += longint'(lfsr[6:0]);
`endif
        s = p >>> 7;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        r = s[15:0];
        return r ^ 16'h8000;
    endfunction

    task automatic set_in(input logic signed [15:0] c0, c1, c2, c3,
                          input logic [7:0] g0, g1, g2, g3, mg);
        ch_in       = {c3, c2, c1, c0};
        ch_gain     = {g3, g2, g1, g0};
        master_gain = mg;
    endtask

    // Each push corresponds to exactly one accepted tick
    task automatic push_model();
        m_lfsr = lfsr_next(m_lfsr);
        exp_q.push_back(model(ch_in, ch_gain, master_gain, m_lfsr));
    endtask

    task automatic push_const(input logic [15:0] v);
        m_lfsr = lfsr_next(m_lfsr);
        exp_q.push_back(v);
    endtask

    task automatic run_sample(input string name, output int vcyc);
        logic [15:0] e;
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 2*DIV) begin
            @(negedge clk);
            n++;
        end
        e = exp_q.pop_front();
        vcyc = cyc;
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s timeout: out_valid=%b required 1", name, out_valid);
        end else begin
            if (out_data !== e) begin
                bad++;
                $display("FAIL %s data: out_data=%h required %h", name, out_data, e);
            end
            total++;
            if (cyc - last_tick_cyc != 7) begin
                bad++;
                $display("FAIL %s latency: got %0d required 7", name, cyc - last_tick_cyc);
            end
            if (out_ready) begin
                @(negedge clk);
                total++;
                if (out_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL %s handshake: out_valid=%b required 0", name, out_valid);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        total += 3;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b required 0", out_valid); end
        if (out_data !== 16'h8000) begin bad++; $display("FAIL reset_data: got %h required 8000", out_data); end
        if (overrun_cnt !== 16'd0) begin bad++; $display("FAIL reset_ovr: got %0d required 0", overrun_cnt); end
    endtask

    task automatic test_timing();
        int v1, v2, v3;
        set_in(16'sd1000, 0, 0, 0, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80);
        push_const(16'h83E8); run_sample("timing1", v1);
        push_const(16'h83E8); run_sample("timing2", v2);
        push_const(16'h83E8); run_sample("timing3", v3);
        total += 2;
        if (v2 - v1 != DIV) begin bad++; $display("FAIL spacing1: got %0d required %0d", v2 - v1, DIV); end
        if (v3 - v2 != DIV) begin bad++; $display("FAIL spacing2: got %0d required %0d", v3 - v2, DIV); end
    endtask

    task automatic test_basic();
        int v;
        set_in(-16'sd1000, 0, 0, 0, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80);
        push_const(16'h7C18); run_sample("neg1000", v);
        set_in(-16'sd300, 16'sd2000, 16'sd12345, -16'sd7, 8'h40, 8'hC0, 8'h11, 8'hFF, 8'h60);
        push_model(); run_sample("mixed", v);
    endtask

    task automatic test_saturation();
        int v;
        set_in(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        push_const(16'hFFFF); run_sample("sat_pos", v);
        set_in(16'h8000, 16'h8000, 16'h8000, 16'h8000, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        push_const(16'h0000); run_sample("sat_neg", v);
    endtask

    task automatic test_overrun();
        int v;
        logic [15:0] hold;
        bit stable;
        out_ready = 1'b0;
        set_in(16'sd1000, 0, 0, 0, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80);
        push_const(16'h83E8); run_sample("ovr_first", v);
        hold = out_data;
        stable = 1'b1;
        repeat (3000) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== hold) stable = 1'b0;
        end
        total += 2;
        if (!stable) begin bad++; $display("FAIL ovr_hold: out_valid=%b out_data=%h required 1 %h", out_valid, out_data, hold); end
        if (overrun_cnt !== 16'd2) begin bad++; $display("FAIL ovr_count: got %0d required 2", overrun_cnt); end
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL ovr_release: out_valid=%b required 0", out_valid); end
        push_const(16'h83E8); run_sample("ovr_resume", v);
    endtask

    task automatic test_reset_mid();
        int n, v;
        n = 0;
        while (dut.u_tick.o_tick !== 1'b1 && n < 2*DIV) begin @(negedge clk); n++; end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total += 3;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid: got %b required 0", out_valid); end
        if (out_data !== 16'h8000) begin bad++; $display("FAIL mid_reset_data: got %h required 8000", out_data); end
        if (overrun_cnt !== 16'd0) begin bad++; $display("FAIL mid_reset_ovr: got %0d required 0", overrun_cnt); end
        reset = 1'b0;
        m_lfsr = c_LFSR_SEED;
        n = 1;
        while (out_valid !== 1'b1 && n < 2*DIV) begin @(negedge clk); n++; end
        total++;
        if (n != DIV + 7) begin bad++; $display("FAIL mid_reset_tick: valid after %0d required %0d", n, DIV + 7); end
        push_const(16'h83E8); run_sample("mid_reset_sample", v);
    endtask

    task automatic test_dither();
        int v;
        set_in(16'sd1, 0, 0, 0, 8'h80, 8'h80, 8'h80, 8'h80, 8'h40);
        for (int i = 0; i < 4; i++) begin
            push_model();
            run_sample("dither", v);
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_basic();
        test_saturation();
        test_overrun();
        test_reset_mid();
        test_dither();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/audio_mix_out.md
Name: audio_mix_out

Overview:
Parametrised successor to the fixed 48 kHz sample-and-truncate path that feeds the DAC. Each sample period it snapshots N_CH signed audio channels and applies a per-channel gain to each. It sums them, applies a master gain, then saturates and converts the result to offset binary. The sample is presented to the DAC SPI driver via a valid/ready handshake, and the block counts dropped samples.

Parameters:
N_CH, 4, number of input channels (1..8)
SIG_BITS, 16, width of each signed input channel
GAIN_BITS, 8, width of unsigned gain words; value 2^(GAIN_BITS-1) = unity, max ≈ 2x
OUT_BITS, 16, output sample width
F_CLK, 50_000_000, clk frequency in Hz
F_SAMPLE, 48_000, output sample rate in Hz; DIV = F_CLK/F_SAMPLE (integer floor, 1041 at defaults)

Ports:
clk  in  1  system clock (50 MHz domain)
reset  in  1  synchronous, active-high reset
ch_in  in  N_CH*SIG_BITS  packed signed channels, channel k at [k*SIG_BITS +: SIG_BITS]
ch_gain  in  N_CH*GAIN_BITS  packed per-channel unsigned gains
master_gain  in  GAIN_BITS  unsigned master gain
out_data  out  OUT_BITS  offset-binary sample for the DAC
out_valid  out  1  sample available; held until accepted
out_ready  in  1  DAC driver accepts the sample on the cycle where out_valid && out_ready
overrun_cnt  out  16  saturating count of dropped sample ticks

Behaviour:
- Reset values: out_valid=0, out_data=2^(OUT_BITS-1) (0x8000, midscale), overrun_cnt=0, prescaler=0, FSM=IDLE, accumulator=0.
- Reset asserted mid-operation aborts the current sample immediately. No partial output is produced.
- Prescaler counts 0..DIV-1 and wraps. tick=1 for exactly one cycle when prescaler==DIV-1.
- A tick is accepted when FSM==IDLE, or when FSM==OUT && out_ready in the same cycle (handshake completes and the new sample starts).
- Any other tick is dropped: overrun_cnt increments and saturates at 0xFFFF. The FSM and the held out_data are not disturbed.
- On an accepted tick, ch_in, ch_gain and master_gain are registered into a snapshot. Later input changes do not affect that sample.
- FSM states and transitions:
  - IDLE: on accepted tick, go to ACC.
  - ACC: N_CH cycles, one channel per cycle, acc += ch[k]*gain[k] (signed × unsigned). Accumulator width SIG_BITS+GAIN_BITS+clog2(N_CH)+1. Then go to SCALE.
  - SCALE: 1 cycle, p = (acc >>> (GAIN_BITS-1)) * master_gain. Then go to SAT.
  - SAT: 1 cycle, s = p >>> (GAIN_BITS-1), arithmetic shift, floor.
    - Saturate s to the signed OUT_BITS range [-2^(OUT_BITS-1), 2^(OUT_BITS-1)-1].
    - out_data = s with MSB inverted; out_valid=1. Then go to OUT.
  - OUT: hold out_data and out_valid stable until out_ready. On handshake, out_valid=0 next cycle and go to IDLE, or to ACC if a tick coincides.
- Latency: out_valid rises N_CH+3 clk edges after the tick cycle (7 at defaults).
- out_ready is ignored while out_valid=0.
- out_data keeps its last value after a handshake.

Optional Feature:
Macro AUDIO_MIX_DITHER_EN.
- Defined:
  - Adds a 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, seeded to 0xACE1 on reset.
  - The LFSR advances once per accepted tick.
  - Its low GAIN_BITS-1 bits are added to p before the SAT shift (TPDF-less rectangular dither).
- Undefined: no LFSR, plain floor truncation. Results must be bit-identical to the non-dither model.

Decomposition:
- Package audio_pkg holds:
  - state enum (IDLE, ACC, SCALE, SAT, OUT)
  - localparam GAIN_UNITY function of GAIN_BITS
  - LFSR seed and tap constants
  - a sat_signed() function used by SAT
- One sub-module, sample_tick_gen, parametrised by F_CLK and F_SAMPLE. It owns the prescaler and the tick output, and is reusable by other audio blocks.

Test Plan:
- Defaults, ready tied high: measure tick spacing → out_valid pulses exactly every 1041 cycles, each rising 7 cycles after its tick.
- ch0=1000, other channels 0, all gains 0x80 → out_data=0x83E8. ch0=-1000 → out_data=0x7C18.
- All four channels 0x7FFF, gains 0xFF, master 0xFF → out_data=0xFFFF. All 0x8000 → out_data=0x0000. Neither case wraps.
- out_ready held low for 3000 cycles after first valid → overrun_cnt=2; out_data and out_valid held unchanged; releasing ready gives one handshake and normal operation resumes.
- Reset pulsed in the 2nd ACC cycle → next cycle out_valid=0, out_data=0x8000, overrun_cnt=0; the next tick arrives 1041 cycles after reset deassertion.
- With AUDIO_MIX_DITHER_EN, constant input ch0=1 and master gain 0x40 → out_data alternates between 0x8000 and 0x8001 according to the LFSR sequence from seed 0xACE1. Without the macro it stays at 0x8000.
